// File: rtl/output_arb_pkg.sv
// Shared types and helpers for the output memory write arbiter.
// Row bursts are BEATS = N/P memory beats long.
package output_arb_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_t;

   function automatic int beats_per_row(input int n, input int p);
      return n / p;
   endfunction

   // Candidate index k positions after the last grant, wrapping at n.
   function automatic int rr_index(input int last, input int k, input int n);
      return (last + k) % n;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker.
// Returns the first valid requester after last_grant, with wrap-around.
module rr_priority_picker
   import output_arb_pkg::*;
#(
   parameter int NUM_WRITERS = 4,
   localparam int GW = ($clog2(NUM_WRITERS) > 1) ? $clog2(NUM_WRITERS) : 1
) (
   input  logic [NUM_WRITERS-1:0] req_valid,
   input  logic [GW-1:0]          last_grant,
   output logic                   any,
   output logic [GW-1:0]          winner
);

   logic [GW-1:0] winner_s;

   // Scan from the farthest candidate down to the nearest so the nearest valid one wins.
   always_comb begin
      winner_s = {GW{1'b0}};
      for (int k = NUM_WRITERS; k >= 1; k--) begin
         winner_s = req_valid[GW'(rr_index(int'(last_grant), k, NUM_WRITERS))]
                    ? GW'(rr_index(int'(last_grant), k, NUM_WRITERS))
                    : winner_s;
      end
   end

   assign any    = |req_valid;
   assign winner = winner_s;

endmodule

// File: rtl/output_write_arbiter.sv
// Shares one output-memory write port among several row writers.
// Ownership is granted round-robin and held for a whole row burst.
module output_write_arbiter
   import output_arb_pkg::*;
#(
   parameter int NUM_WRITERS                    = 4,
   parameter int OUTPUT_DATA_WIDTH              = 18,
   parameter int B_N                            = 2,
   parameter int B_PARALLEL_DATA_STREAMING_SIZE = 2,
   parameter int B_MEMORY_ADDRESS_BITS          = 6,
   localparam int N     = 1 << B_N,
   localparam int P     = 1 << B_PARALLEL_DATA_STREAMING_SIZE,
   localparam int MAB   = 1 << B_MEMORY_ADDRESS_BITS,
   localparam int ODW   = OUTPUT_DATA_WIDTH,
   localparam int GW    = ($clog2(NUM_WRITERS) > 1) ? $clog2(NUM_WRITERS) : 1
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_WRITERS-1:0]                req_valid,
   output logic [NUM_WRITERS-1:0]                req_ready,
   input  logic [NUM_WRITERS-1:0][MAB-1:0]       req_address,
   input  logic [NUM_WRITERS-1:0][P-1:0][ODW-1:0] req_data,
   output logic                                  mem_write_valid,
   input  logic                                  mem_write_ready,
   output logic [MAB-1:0]                        mem_write_address,
   output logic [P-1:0][ODW-1:0]                 mem_write_data,
   output logic [GW-1:0]                         grant_id,
   output logic                                  grant_active
);

   localparam int BEATS = beats_per_row(N, P);
   localparam int CW    = $clog2(BEATS) + 1;

   if ((N % P) != 0) begin : g_bad_streaming_size
      $error("output_write_arbiter: P must divide N");
   end
   if (NUM_WRITERS < 2) begin : g_bad_num_writers
      $error("output_write_arbiter: NUM_WRITERS must be at least 2");
   end

   arb_state_t    state_r;
   logic [CW-1:0] beat_cnt_r;
   logic [GW-1:0] last_grant_r;
   logic [GW-1:0] grant_id_r;
   logic          pick_any_s;
   logic [GW-1:0] pick_winner_s;
   logic          beat_accept_s;

   rr_priority_picker #(
      .NUM_WRITERS (NUM_WRITERS)
   ) u_picker (
      .req_valid  (req_valid),
      .last_grant (last_grant_r),
      .any        (pick_any_s),
      .winner     (pick_winner_s)
   );

   assign beat_accept_s = mem_write_valid & mem_write_ready;

   // Arbitration state, beat counter and grant registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ARB_IDLE;
         beat_cnt_r   <= {CW{1'b0}};
         last_grant_r <= GW'(NUM_WRITERS - 1);
         grant_id_r   <= {GW{1'b0}};
      end else begin
         case (state_r)
            ARB_IDLE: begin
               if (pick_any_s) begin
                  grant_id_r <= pick_winner_s;
                  state_r    <= ARB_BURST;
               end else begin
                  state_r    <= ARB_IDLE;
               end
            end
            ARB_BURST: begin
               if (beat_accept_s) begin
                  if (beat_cnt_r == CW'(BEATS - 1)) begin
                     beat_cnt_r   <= {CW{1'b0}};
                     last_grant_r <= grant_id_r;
                     state_r      <= ARB_IDLE;
                  end else begin
                     beat_cnt_r   <= beat_cnt_r + CW'(1);
                  end
               end else begin
                  beat_cnt_r <= beat_cnt_r;
               end
            end
            default: begin
               state_r    <= ARB_IDLE;
               beat_cnt_r <= {CW{1'b0}};
            end
         endcase
      end
   end

   // Zero-latency pass-through of the owner's beat; everything is zero outside a burst.
   always_comb begin
      req_ready         = {NUM_WRITERS{1'b0}};
      mem_write_valid   = 1'b0;
      mem_write_address = {MAB{1'b0}};
      mem_write_data    = {(P * ODW){1'b0}};
      if (state_r == ARB_BURST) begin
         mem_write_valid       = req_valid[grant_id_r];
         mem_write_address     = req_address[grant_id_r];
         mem_write_data        = req_data[grant_id_r];
         req_ready[grant_id_r] = mem_write_ready;
      end else begin
         req_ready         = {NUM_WRITERS{1'b0}};
         mem_write_valid   = 1'b0;
      end
   end

   assign grant_id     = grant_id_r;
   assign grant_active = (state_r == ARB_BURST);

endmodule

// File: tb/tb_output_write_arbiter.sv
// Randomized bench: two arbiters (one-beat rows and two-beat rows) share stimulus
// and are checked every cycle against a row-burst ownership model.
module tb_output_write_arbiter;

   localparam int NW  = 4;
   localparam int ODW = 18;
   localparam int P   = 4;
   localparam int MAB = 64;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [NW-1:0]                req_valid = '0;
   logic [NW-1:0][MAB-1:0]       req_address = '0;
   logic [NW-1:0][P-1:0][ODW-1:0] req_data = '0;
   logic                         mem_write_ready = 1'b0;

   logic [NW-1:0]          a_req_ready, b_req_ready;
   logic                   a_mem_valid, b_mem_valid;
   logic [MAB-1:0]         a_mem_addr, b_mem_addr;
   logic [P-1:0][ODW-1:0]  a_mem_data, b_mem_data;
   logic [1:0]             a_grant_id, b_grant_id;
   logic                   a_grant_active, b_grant_active;

   int checks = 0;
   int errors = 0;

   // Reference state per DUT: owner -1 means no burst in progress.
   int m_owner[2];
   int m_done[2];
   int m_last[2];
   int m_gid[2];
   int beats_cfg[2] = '{1, 2};

   always #5 clk = ~clk;

   output_write_arbiter #(
      .NUM_WRITERS (NW), .OUTPUT_DATA_WIDTH (ODW), .B_N (2),
      .B_PARALLEL_DATA_STREAMING_SIZE (2), .B_MEMORY_ADDRESS_BITS (6)
   ) dut_a (
      .clk (clk), .reset (reset),
      .req_valid (req_valid), .req_ready (a_req_ready),
      .req_address (req_address), .req_data (req_data),
      .mem_write_valid (a_mem_valid), .mem_write_ready (mem_write_ready),
      .mem_write_address (a_mem_addr), .mem_write_data (a_mem_data),
      .grant_id (a_grant_id), .grant_active (a_grant_active)
   );

   output_write_arbiter #(
      .NUM_WRITERS (NW), .OUTPUT_DATA_WIDTH (ODW), .B_N (3),
      .B_PARALLEL_DATA_STREAMING_SIZE (2), .B_MEMORY_ADDRESS_BITS (6)
   ) dut_b (
      .clk (clk), .reset (reset),
      .req_valid (req_valid), .req_ready (b_req_ready),
      .req_address (req_address), .req_data (req_data),
      .mem_write_valid (b_mem_valid), .mem_write_ready (mem_write_ready),
      .mem_write_address (b_mem_addr), .mem_write_data (b_mem_data),
      .grant_id (b_grant_id), .grant_active (b_grant_active)
   );

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_owner[d] = -1;
         m_done[d]  = 0;
         m_last[d]  = NW - 1;
         m_gid[d]   = 0;
      end
   endtask

   task automatic compare_dut(input int d, input logic mv, input logic [NW-1:0] rr,
                              input logic [MAB-1:0] addr, input logic [P-1:0][ODW-1:0] data,
                              input logic [1:0] gid, input logic ga);
      logic                  ev;
      logic [NW-1:0]         er;
      logic [MAB-1:0]        ea;
      logic [P-1:0][ODW-1:0] ed;
      ev = 1'b0; er = '0; ea = '0; ed = '0;
      if (m_owner[d] >= 0) begin
         ev = req_valid[m_owner[d]];
         ea = req_address[m_owner[d]];
         ed = req_data[m_owner[d]];
         if (mem_write_ready) er[m_owner[d]] = 1'b1;
      end
      check_eq($sformatf("d%0d_mem_valid", d), 128'(mv), 128'(ev));
      check_eq($sformatf("d%0d_req_ready", d), 128'(rr), 128'(er));
      check_eq($sformatf("d%0d_mem_addr", d), 128'(addr), 128'(ea));
      check_eq($sformatf("d%0d_mem_data", d), 128'(data), 128'(ed));
      check_eq($sformatf("d%0d_grant_id", d), 128'(gid), 128'(m_gid[d]));
      check_eq($sformatf("d%0d_grant_active", d), 128'(ga), 128'(m_owner[d] >= 0));
   endtask

   // Advance the model over the coming clock edge using the inputs now applied.
   task automatic model_step(input int d, input logic rst);
      int idx;
      if (rst) begin
         m_owner[d] = -1; m_done[d] = 0; m_last[d] = NW - 1; m_gid[d] = 0;
      end else if (m_owner[d] < 0) begin
         for (int k = 1; k <= NW; k++) begin
            idx = (m_last[d] + k) % NW;
            if (m_owner[d] < 0 && req_valid[idx]) begin
               m_owner[d] = idx;
               m_gid[d]   = idx;
            end
         end
      end else if (req_valid[m_owner[d]] && mem_write_ready) begin
         m_done[d]++;
         if (m_done[d] == beats_cfg[d]) begin
            m_done[d]  = 0;
            m_last[d]  = m_owner[d];
            m_owner[d] = -1;
         end
      end
   endtask

   task automatic cycle(input logic [NW-1:0] rv, input logic rdy, input logic rst, input bit chk);
      @(negedge clk);
      req_valid       = rv;
      mem_write_ready = rdy;
      reset           = rst;
      for (int w = 0; w < NW; w++) begin
         req_address[w] = {$urandom, $urandom};
         for (int e = 0; e < P; e++) req_data[w][e] = ODW'($urandom);
      end
      #1;
      if (chk) begin
         compare_dut(0, a_mem_valid, a_req_ready, a_mem_addr, a_mem_data, a_grant_id, a_grant_active);
         compare_dut(1, b_mem_valid, b_req_ready, b_mem_addr, b_mem_data, b_grant_id, b_grant_active);
      end
      model_step(0, rst);
      model_step(1, rst);
   endtask

   initial begin
      int seq[$];
      int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
      logic prev_active;
      logic [NW-1:0] rv;
      model_reset();
      cycle(4'h0, 1'b0, 1'b1, 1'b0);
      cycle(4'h0, 1'b0, 1'b1, 1'b0);
      cycle(4'h0, 1'b1, 1'b0, 1'b1);   // reset state with nothing requested

      // All writers requesting, memory always ready: one-beat rows rotate 0,1,2,3,0,1.
      cycle(4'h0, 1'b1, 1'b1, 1'b1);
      prev_active = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cycle(4'hF, 1'b1, 1'b0, 1'b1);
         if (a_grant_active && !prev_active) seq.push_back(int'(a_grant_id));
         prev_active = a_grant_active;
      end
      check_eq("rotation_len", 128'(seq.size() >= 6), 128'(1));
      for (int i = 0; i < 6; i++)
         check_eq($sformatf("rotation_%0d", i), 128'(i < seq.size() ? seq[i] : -1), 128'(exp_seq[i]));

      // Backpressure and owner stalls inside two-beat rows, then reset mid-burst.
      cycle(4'h0, 1'b1, 1'b1, 1'b1);
      cycle(4'h1, 1'b1, 1'b0, 1'b1);
      cycle(4'h3, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(4'h3, 1'b0, 1'b0, 1'b1);
      cycle(4'h3, 1'b1, 1'b0, 1'b1);
      cycle(4'h6, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 2; i++) cycle(4'h4, 1'b1, 1'b0, 1'b1);
      cycle(4'h5, 1'b1, 1'b0, 1'b1);
      cycle(4'h9, 1'b1, 1'b0, 1'b1);
      cycle(4'h9, 1'b1, 1'b0, 1'b1);
      cycle(4'h9, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) cycle(4'h9, 1'b1, 1'b0, 1'b1);
      check_eq("after_reset_owner", 128'(m_last[1] == 0 || m_owner[1] == 0), 128'(1));

      // Random traffic with random backpressure and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         rv = NW'($urandom);
         if ((i / 300) % 2 == 1) rv = rv | NW'($urandom);
         cycle(rv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
